// File: rtl/bpm_pkg.sv
// bpm_pkg: shared FSM encoding and accumulator width derivation for the baseline averager
package bpm_pkg;
  typedef enum logic [1:0] {IDLE, ACC, DIV, DONE} blState_e;
  function automatic int accWidth(input int adcBit, input int log2MaxWin);
    return adcBit + log2MaxWin;
  endfunction
endpackage

// File: rtl/baseline_div.sv
// baseline_div: sequential restoring unsigned divider with a fixed DIVIDEND_W-cycle latency
module baseline_div
  import bpm_pkg::*;
#(
  parameter int DIVIDEND_W = 24,
  parameter int DIVISOR_W = 9,
  parameter int QUOT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [QUOT_W-1:0]     quotient,
  output logic                  done
);
  localparam int IW = $clog2(DIVIDEND_W);
  logic [DIVIDEND_W-1:0] quo;
  logic [DIVISOR_W-1:0] rem, den, diff;
  logic [DIVISOR_W:0] trial;
  logic [IW-1:0] iter;
  logic run, fits;
  assign trial = {rem, quo[DIVIDEND_W-1]};
  assign fits = trial >= {1'b0, den};
  assign diff = DIVISOR_W'(trial - {1'b0, den});
  // done marks the cycle whose edge writes the last quotient bit; the quotient is final right after
  assign done = run && (iter == IW'(DIVIDEND_W - 1));
  assign quotient = quo[QUOT_W-1:0];
  // One restoring step per cycle: shift a dividend bit into the remainder, subtract if it fits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo <= '0;
      rem <= '0;
      den <= '0;
      iter <= '0;
      run <= 1'b0;
    end else if (start) begin
      quo <= dividend;
      rem <= '0;
      den <= divisor;
      iter <= '0;
      run <= 1'b1;
    end else if (run) begin
      quo <= {quo[DIVIDEND_W-2:0], fits};
      rem <= fits ? diff : trial[DIVISOR_W-1:0];
      iter <= iter + IW'(1);
      run <= !done;
    end
  end
endmodule

// File: rtl/baseline_avg.sv
// baseline_avg: gated per-channel baseline averager with shift fast path and divider gap path
module baseline_avg
  import bpm_pkg::*;
#(
  parameter int ADC_BIT = 16,
  parameter int N_CH = 4,
  parameter int LOG2_MAX_WIN = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [N_CH*ADC_BIT-1:0]   din,
  input  logic [3:0]                win_log2,
  output logic                      out_valid,
  output logic [N_CH*ADC_BIT-1:0]   BL_data,
  output logic [LOG2_MAX_WIN:0]     bl_count,
  output logic                      busy
);
  localparam int ACC_W = accWidth(ADC_BIT, LOG2_MAX_WIN);
  localparam int CW = LOG2_MAX_WIN + 1;
  blState_e state, stateNext;
  logic [ADC_BIT-1:0] lane [N_CH];
  logic [ACC_W-1:0] acc [N_CH];
  logic [ACC_W-1:0] accSum [N_CH];
  logic [ADC_BIT-1:0] res [N_CH];
  logic [ADC_BIT-1:0] quot [N_CH];
  logic [N_CH-1:0] divDoneV;
  logic [CW-1:0] cnt, cntInc, winSize;
  logic [3:0] win, winClamp;
  logic armed, divUsed, divStart, divDone;
  assign cntInc = cnt + CW'(1);
  assign winSize = CW'(1) << win;
  assign winClamp = (win_log2 > 4'(LOG2_MAX_WIN)) ? 4'(LOG2_MAX_WIN) : win_log2;
  assign divStart = (state == ACC) && !in_valid;
  assign divDone = &divDoneV;
  assign busy = state != IDLE;
  for (genvar c = 0; c < N_CH; c++) begin : gLane
    assign lane[c] = din[c*ADC_BIT +: ADC_BIT];
    assign accSum[c] = acc[c] + ACC_W'(lane[c]);
    baseline_div #(
      .DIVIDEND_W(ACC_W),
      .DIVISOR_W(CW),
      .QUOT_W(ADC_BIT)
    ) uDiv (
      .clk(clk),
      .rst(rst),
      .start(divStart),
      .dividend(acc[c]),
      .divisor(cnt),
      .quotient(quot[c]),
      .done(divDoneV[c])
    );
  end
  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= stateNext;
  end
  // Next state: a zero exponent closes the window on its first sample
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (in_valid && armed) stateNext = (winClamp == 4'd0) ? DONE : ACC;
      ACC: if (!in_valid) stateNext = DIV;
           else if (cntInc == winSize) stateNext = DONE;
      DIV: if (divDone) stateNext = DONE;
      DONE: stateNext = IDLE;
    endcase
  end
  // Datapath: accumulate, track the shifted mean for the fast path, publish on DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < N_CH; c++) begin
        acc[c] <= '0;
        res[c] <= '0;
      end
      cnt <= '0;
      win <= '0;
      armed <= 1'b1;
      divUsed <= 1'b0;
      out_valid <= 1'b0;
      BL_data <= '0;
      bl_count <= '0;
    end else begin
      out_valid <= 1'b0;
      if (!in_valid) armed <= 1'b1;
      case (state)
        IDLE: if (in_valid && armed) begin
          armed <= 1'b0;
          cnt <= CW'(1);
          win <= winClamp;
          divUsed <= 1'b0;
          for (int c = 0; c < N_CH; c++) begin
            acc[c] <= ACC_W'(lane[c]);
            res[c] <= lane[c];
          end
        end
        ACC: if (in_valid) begin
          cnt <= cntInc;
          for (int c = 0; c < N_CH; c++) begin
            acc[c] <= accSum[c];
            res[c] <= ADC_BIT'(accSum[c] >> win);
          end
        end else divUsed <= 1'b1;
        DONE: begin
          out_valid <= 1'b1;
          bl_count <= cnt;
          for (int c = 0; c < N_CH; c++)
            BL_data[c*ADC_BIT +: ADC_BIT] <= divUsed ? quot[c] : res[c];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_baseline_avg.sv
// tb_baseline_avg: directed scoreboard bench for baseline_avg
module tb_baseline_avg;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic [63:0] din = '0;
  logic [3:0] win_log2 = '0;
  logic out_valid;
  logic [63:0] BL_data;
  logic [8:0] bl_count;
  logic busy;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic chkZero = 1'b0;
  logic chkEmpty = 1'b0;
  logic [63:0] la, lb, le;
  typedef struct {
    logic [63:0] data;
    logic [8:0] cnt;
    int lat;
    int mark;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  baseline_avg dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .din(din),
    .win_log2(win_log2),
    .out_valid(out_valid),
    .BL_data(BL_data),
    .bl_count(bl_count),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] rep(input logic [15:0] v);
    return {4{v}};
  endfunction

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: reset-state probes, drain check and scoreboard comparison on every out_valid
  always @(negedge clk) begin
    if (chkZero) begin
      cmp("rst_out_valid", 64'(out_valid), 64'd0);
      cmp("rst_busy", 64'(busy), 64'd0);
      cmp("rst_BL_data", BL_data, 64'd0);
      cmp("rst_bl_count", 64'(bl_count), 64'd0);
    end
    if (chkEmpty) cmp("scoreboard_drained", 64'(sb.size()), 64'd0);
    if (rst && out_valid) begin
      if (sb.size() == 0) cmp("unexpected_out_valid", 64'(out_valid), 64'd0);
      else begin
        e = sb.pop_front();
        cmp("BL_data", BL_data, e.data);
        cmp("bl_count", 64'(bl_count), 64'(e.cnt));
        cmp("latency", 64'(cyc - e.mark + 1), 64'(e.lat));
      end
    end
  end

  task automatic sample(input logic [63:0] v);
    @(negedge clk);
    in_valid = 1'b1;
    din = v;
  endtask

  task automatic lowFor(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      din = '0;
    end
  endtask

  task automatic expectAt(input logic [63:0] d, input logic [8:0] n, input int lat);
    @(posedge clk);
    #1;
    sb.push_back('{d, n, lat, cyc});
  endtask

  task automatic zeroCheck();
    @(posedge clk);
    #1 chkZero = 1'b1;
    @(negedge clk);
    #1 chkZero = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    zeroCheck();
    @(negedge clk);
    rst = 1'b1;
    win_log2 = 4'd2;
    sample(rep(16'd100));
    sample(rep(16'd200));
    win_log2 = 4'd0;
    sample(rep(16'd300));
    sample(rep(16'd400));
    expectAt(rep(16'd250), 9'd4, 2);
    lowFor(4);
    for (int c = 0; c < 4; c++) begin
      la[c*16 +: 16] = 16'(10 * (c + 1));
      lb[c*16 +: 16] = 16'(10 * (c + 1) + 2);
      le[c*16 +: 16] = 16'(10 * (c + 1) + 1);
    end
    win_log2 = 4'd1;
    sample(la);
    sample(lb);
    expectAt(le, 9'd2, 2);
    lowFor(4);
    win_log2 = 4'd3;
    sample(rep(16'd10));
    sample(rep(16'd11));
    sample(rep(16'd13));
    lowFor(1);
    expectAt(rep(16'd11), 9'd3, 26);
    lowFor(30);
    win_log2 = 4'd0;
    sample(rep(16'd777));
    expectAt(rep(16'd777), 9'd1, 2);
    lowFor(4);
    win_log2 = 4'd2;
    for (int i = 0; i < 10; i++) begin
      sample(rep(16'(4 * (i + 1))));
      if (i == 3) expectAt(rep(16'd10), 9'd4, 2);
    end
    lowFor(1);
    sample(rep(16'd1));
    sample(rep(16'd2));
    sample(rep(16'd3));
    sample(rep(16'd5));
    expectAt(rep(16'd2), 9'd4, 2);
    lowFor(4);
    win_log2 = 4'd8;
    for (int i = 0; i < 256; i++) sample(rep(16'hFFFF));
    expectAt(rep(16'hFFFF), 9'd256, 2);
    lowFor(4);
    win_log2 = 4'd15;
    for (int i = 0; i < 256; i++) sample(rep(16'(i)));
    expectAt(rep(16'd127), 9'd256, 2);
    lowFor(4);
    win_log2 = 4'd3;
    sample(rep(16'd50));
    sample(rep(16'd60));
    lowFor(6);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    zeroCheck();
    lowFor(30);
    win_log2 = 4'd2;
    sample(rep(16'd5));
    sample(rep(16'd8));
    lowFor(1);
    expectAt(rep(16'd6), 9'd2, 26);
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    lowFor(2);
    @(posedge clk);
    #1 chkEmpty = 1'b1;
    @(negedge clk);
    #1 chkEmpty = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
